adc_scan_ctrl: RTL and testbench
================================

Name: adc_scan_ctrl

Overview:
- Sequencer directly upstream/downstream of spi_master in the acquisition path; drives its start/data_in and consumes its data_out/new_data.
- Scans a programmable set of ADC channels over SPI, addressing the multiplexer one frame ahead (ADC returns the previous frame's channel).
- Tags each result with its channel and buffers it in a small FIFO for the acquisition logic.

Parameters:
DATA_WIDTH, 16, SPI frame width; must equal spi_master DATA_WIDTH
NUM_CH, 8, number of ADC channels (2..16)
CH_WIDTH, 3, channel index width, $clog2(NUM_CH)
CMD_SHIFT, 11, bit position of channel field in command word
GAP_CYCLES, 4, idle clk cycles between frames (>=1, CS-high time)
FIFO_DEPTH, 4, sample FIFO entries (power of 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
scan_start  in  1  one-cycle pulse, begin scan
cont  in  1  1 = restart scan automatically after each completion
ch_mask  in  NUM_CH  enabled channels, latched at scan start
spi_start  out  1  start pulse to spi_master
spi_data_in  out  DATA_WIDTH  command word to spi_master
spi_busy  in  1  spi_master busy
spi_new_data  in  1  spi_master result strobe
spi_data_out  in  DATA_WIDTH  spi_master received word
sample_data  out  DATA_WIDTH  FIFO head data
sample_ch  out  CH_WIDTH  FIFO head channel tag
sample_valid  out  1  FIFO not empty
sample_ready  in  1  consumer accepts head when valid&ready
scan_busy  out  1  scan in progress
scan_done  out  1  one-cycle pulse after last result of a scan written/dropped
overflow  out  1  sticky: result dropped on full FIFO
overflow_clr  in  1  clears overflow

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM IDLE. Shared rst with spi_master; reset mid-scan abandons scan, no partial sample emitted.
- Command word: spi_data_in = ch << CMD_SHIFT, other bits 0; held stable from spi_start until next command loaded.
- Channel order: ascending index among latched mask bits; "next" = lowest set bit above current, wrap to lowest set bit.
- Pipelined addressing: scan with k enabled channels issues k+1 frames. Frame 0 addresses ch[0]; result discarded. Frame i (1..k) addresses ch[i] (frame k addresses ch[0] again, wrap) and its result is tagged ch[i-1].
- FSM: IDLE -> (scan_start & ch_mask!=0) latch mask, frame counter=0 -> START. scan_start with mask 0 or while scan_busy: ignored.
  START: spi_start=1 for exactly one cycle -> WAIT.
  WAIT: hold until spi_new_data; then if frame>0 push {tag,spi_data_out}; -> GAP.
  GAP: count GAP_CYCLES, then if frame==k -> END else frame++, advance channel -> START.
  END: scan_done=1 one cycle; if cont -> START with new frame 0 (mask re-latched from ch_mask; if zero -> IDLE); else -> IDLE.
- scan_busy = state != IDLE.
- cont cleared mid-scan: current scan completes, then IDLE.
- spi_start is never asserted while spi_busy=1.
- FIFO: first-word-fall-through; push and pop same cycle allowed when full (pop frees slot, push succeeds). Push on full (without pop): sample dropped, overflow<=1.
- overflow_clr and new overflow event same cycle: overflow stays 1.
- Pointers wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1.
- Throughput: frame period = spi transfer + GAP_CYCLES + 2 cycles overhead.

Test Plan:
- Mask 8'h01, single shot, spi model returns 16'h0ABC each frame -> 2 frames, commands 16'h0000,16'h0000; one sample ch=0 data=16'h0ABC; scan_done once; scan_busy 0 after.
- Mask 8'h25, slave returns 16'h1000+addressed ch of previous frame -> commands ch 0,2,5,0 (16'h0000,16'h1000,16'h2800,16'h0000); samples (0,16'h1000),(2,16'h1002),(5,16'h1005) in order.
- Mask 8'hFF, sample_ready=0, FIFO_DEPTH=4 -> first 4 samples (ch0..3) retained, overflow=1 after 5th; overflow_clr pulse -> 0; drain yields ch0..3.
- cont=1, mask 8'h03 -> back-to-back scans, scan_done each; drop cont mid-scan -> that scan finishes, IDLE, no further spi_start.
- scan_start with mask 0 -> no spi_start; scan_start pulsed during scan -> ignored, frame count unchanged.
- rst asserted in WAIT -> next cycle all outputs 0, sample_valid 0; new scan_start after release runs normally.

Source files
------------

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: scans enabled ADC channels through spi_master, addressing the mux one frame
// ahead, and queues channel-tagged results in a first-word-fall-through FIFO.
`default_nettype none

module adc_scan_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 8,
  parameter int CH_WIDTH   = 3,
  parameter int CMD_SHIFT  = 11,
  parameter int GAP_CYCLES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_start,
  input  logic                  cont,
  input  logic [NUM_CH-1:0]     ch_mask,
  output logic                  spi_start,
  output logic [DATA_WIDTH-1:0] spi_data_in,
  input  logic                  spi_busy,
  input  logic                  spi_new_data,
  input  logic [DATA_WIDTH-1:0] spi_data_out,
  output logic [DATA_WIDTH-1:0] sample_data,
  output logic [CH_WIDTH-1:0]   sample_ch,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  scan_busy,
  output logic                  scan_done,
  output logic                  overflow,
  input  logic                  overflow_clr
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int FR_W   = CH_WIDTH + 1;
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int WORD_W = CH_WIDTH + DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_END   = 3'd4
  } state_t;

  state_t              state;
  logic [NUM_CH-1:0]   mask;
  logic [FR_W-1:0]     num_frames;
  logic [FR_W-1:0]     frame;
  logic [CH_WIDTH-1:0] cur_ch;
  logic [CH_WIDTH-1:0] prev_ch;
  logic [GAP_W-1:0]    gap_cnt;

  function automatic logic [CH_WIDTH-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
    logic [CH_WIDTH-1:0] lo;
    lo = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) lo = CH_WIDTH'(i);
    end
    return lo;
  endfunction

  // Lowest enabled channel above cur, wrapping to the lowest enabled channel.
  function automatic logic [CH_WIDTH-1:0] next_ch(input logic [NUM_CH-1:0] m,
                                                  input logic [CH_WIDTH-1:0] cur);
    logic [CH_WIDTH-1:0] lo;
    logic [CH_WIDTH-1:0] hi;
    logic                hi_found;
    lo       = '0;
    hi       = '0;
    hi_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) begin
        lo = CH_WIDTH'(i);
        if (i > int'(cur)) begin
          hi       = CH_WIDTH'(i);
          hi_found = 1'b1;
        end
      end
    end
    return hi_found ? hi : lo;
  endfunction

  function automatic logic [FR_W-1:0] popcount(input logic [NUM_CH-1:0] m);
    logic [FR_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = c + FR_W'(m[i]);
    end
    return c;
  endfunction

  assign scan_busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      mask        <= '0;
      num_frames  <= '0;
      frame       <= '0;
      cur_ch      <= '0;
      prev_ch     <= '0;
      gap_cnt     <= '0;
      spi_start   <= 1'b0;
      spi_data_in <= '0;
      scan_done   <= 1'b0;
    end else begin
      spi_start <= 1'b0;
      scan_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (scan_start && (ch_mask != '0)) begin
            mask       <= ch_mask;
            num_frames <= popcount(ch_mask);
            frame      <= '0;
            cur_ch     <= lowest_ch(ch_mask);
            state      <= S_START;
          end
        end
        S_START: begin
          if (!spi_busy) begin
            spi_start   <= 1'b1;
            spi_data_in <= DATA_WIDTH'(cur_ch) << CMD_SHIFT;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (spi_new_data) begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            if (frame == num_frames) begin
              scan_done <= 1'b1;
              state     <= S_END;
            end else begin
              frame   <= frame + 1'b1;
              prev_ch <= cur_ch;
              cur_ch  <= next_ch(mask, cur_ch);
              state   <= S_START;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_END: begin
          if (cont && (ch_mask != '0)) begin
            mask       <= ch_mask;
            num_frames <= popcount(ch_mask);
            frame      <= '0;
            cur_ch     <= lowest_ch(ch_mask);
            state      <= S_START;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Frame 0 only primes the mux; its result belongs to no channel of this scan.
  logic              push;
  logic              pop;
  logic              full;
  logic              push_ok;
  logic [WORD_W-1:0] push_word;
  logic [WORD_W-1:0] head_word;

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  assign push      = (state == S_WAIT) && spi_new_data && (frame != '0);
  assign push_word = {prev_ch, spi_data_out};
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign pop       = sample_valid && sample_ready;
  assign push_ok   = push && (!full || pop);

  assign sample_valid = (count != '0);
  assign head_word    = mem[rd_ptr];
  assign sample_data  = sample_valid ? head_word[DATA_WIDTH-1:0] : '0;
  assign sample_ch    = sample_valid ? head_word[WORD_W-1:DATA_WIDTH] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !push_ok) overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adc_scan_ctrl.sv
// Self-checking bench for adc_scan_ctrl: behavioural spi slave, sample collector and a
// list-based model of the expected command and sample sequences.
`default_nettype none

module tb_adc_scan_ctrl;

  localparam int DW  = 16;
  localparam int NCH = 8;
  localparam int CHW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           scan_start;
  logic           cont;
  logic [NCH-1:0] ch_mask;
  logic           spi_start;
  logic [DW-1:0]  spi_data_in;
  logic           spi_busy;
  logic           spi_new_data;
  logic [DW-1:0]  spi_data_out;
  logic [DW-1:0]  sample_data;
  logic [CHW-1:0] sample_ch;
  logic           sample_valid;
  logic           sample_ready;
  logic           scan_busy;
  logic           scan_done;
  logic           overflow;
  logic           overflow_clr;

  always #5 clk = ~clk;

  adc_scan_ctrl #(
    .DATA_WIDTH(DW), .NUM_CH(NCH), .CH_WIDTH(CHW),
    .CMD_SHIFT(11), .GAP_CYCLES(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .scan_start(scan_start), .cont(cont), .ch_mask(ch_mask),
    .spi_start(spi_start), .spi_data_in(spi_data_in), .spi_busy(spi_busy),
    .spi_new_data(spi_new_data), .spi_data_out(spi_data_out),
    .sample_data(sample_data), .sample_ch(sample_ch), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .scan_busy(scan_busy), .scan_done(scan_done),
    .overflow(overflow), .overflow_clr(overflow_clr)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // spi slave: returns base + channel addressed by the previous frame
  logic [DW-1:0]  base;
  logic [CHW-1:0] slv_cur;
  logic [CHW-1:0] slv_prev;
  int             slv_cnt;
  logic [DW-1:0]  cmd_q[$];
  logic [CHW+DW-1:0] got_q[$];
  int done_cnt  = 0;
  int start_cnt = 0;

  always @(posedge clk) begin
    spi_new_data <= 1'b0;
    if (rst) begin
      spi_busy <= 1'b0;
      slv_cnt  <= 0;
    end else if (spi_busy) begin
      if (slv_cnt == 0) begin
        spi_busy     <= 1'b0;
        spi_new_data <= 1'b1;
        spi_data_out <= base + DW'(slv_prev);
        slv_prev     <= slv_cur;
      end else begin
        slv_cnt <= slv_cnt - 1;
      end
    end else if (spi_start) begin
      spi_busy <= 1'b1;
      slv_cnt  <= int'($urandom_range(1, 6));
      slv_cur  <= spi_data_in[13:11];
      cmd_q.push_back(spi_data_in);
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (scan_done) done_cnt++;
      if (spi_start) begin
        start_cnt++;
        check("start_while_busy", 32'(spi_busy), 32'd0);
      end
      if (sample_valid && sample_ready) got_q.push_back({sample_ch, sample_data});
    end
  end

  task automatic pulse_start(input logic [NCH-1:0] m);
    ch_mask    = m;
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target);
    int t = 0;
    while ((done_cnt < target || scan_busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_timeout"}, 32'(t < 3000), 32'd1);
  endtask

  // Single-shot scan compared against the channel-list model; poke fires an ignored start.
  task automatic run_scan(input logic [NCH-1:0] m, input logic [DW-1:0] b,
                          input bit poke, input string tag);
    logic [CHW-1:0] lst[$];
    logic [DW-1:0]  exp_cmd;
    int             k;
    int             d0;
    base = b;
    cmd_q.delete();
    got_q.delete();
    d0 = done_cnt;
    pulse_start(m);
    if (poke) begin
      repeat (5) @(negedge clk);
      pulse_start(8'hFF);
    end
    wait_done(tag, d0 + 1);
    repeat (6) @(negedge clk);
    for (int i = 0; i < NCH; i++) if (m[i]) lst.push_back(CHW'(i));
    k = lst.size();
    check({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_n_cmd"}, 32'(cmd_q.size()), 32'(k + 1));
    for (int i = 0; i <= k && i < cmd_q.size(); i++) begin
      exp_cmd = DW'(lst[(i < k) ? i : 0]) << 11;
      check({tag, "_cmd"}, 32'(cmd_q[i]), 32'(exp_cmd));
    end
    check({tag, "_n_smp"}, 32'(got_q.size()), 32'(k));
    for (int i = 0; i < k && i < got_q.size(); i++)
      check({tag, "_smp"}, 32'(got_q[i]), 32'({lst[i], DW'(b + DW'(lst[i]))}));
    check({tag, "_busy"}, 32'(scan_busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int s0;
    int t;
    rst = 1'b1; scan_start = 1'b0; cont = 1'b0; ch_mask = '0;
    sample_ready = 1'b1; overflow_clr = 1'b0; base = '0;
    slv_prev = '0; slv_cur = '0; spi_data_out = '0;
    repeat (3) @(negedge clk);
    check("rst_spi_start", 32'(spi_start), 32'd0);
    check("rst_cmd", 32'(spi_data_in), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_busy", 32'(scan_busy), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_scan(8'h01, 16'h0ABC, 1'b0, "single");
    run_scan(8'h25, 16'h1000, 1'b0, "mask25");

    // Overflow: 8 results into a 4-entry FIFO with no consumer
    sample_ready = 1'b0;
    base = 16'h2000;
    got_q.delete();
    d0 = done_cnt;
    pulse_start(8'hFF);
    wait_done("ovf", d0 + 1);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_valid", 32'(sample_valid), 32'd1);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
    sample_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("ovf_n_drain", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check("ovf_drain", 32'(got_q[i]), 32'({CHW'(i), DW'(16'h2000 + i)}));

    // Continuous scanning, cont dropped after the second completion
    base = 16'h3000;
    cmd_q.delete();
    got_q.delete();
    cont = 1'b1;
    d0 = done_cnt;
    pulse_start(8'h03);
    t = 0;
    while (done_cnt < d0 + 2 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("cont_timeout", 32'(t < 3000), 32'd1);
    cont = 1'b0;
    wait_done("cont_end", d0 + 3);
    repeat (6) @(negedge clk);
    check("cont_dones", 32'(done_cnt - d0), 32'd3);
    check("cont_n_cmd", 32'(cmd_q.size()), 32'd9);
    check("cont_n_smp", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < got_q.size(); i++)
      check("cont_smp", 32'(got_q[i]), 32'({CHW'(i % 2), DW'(16'h3000 + (i % 2))}));
    s0 = start_cnt;
    repeat (40) @(negedge clk);
    check("cont_quiet", 32'(start_cnt), 32'(s0));
    check("cont_idle", 32'(scan_busy), 32'd0);

    // Zero mask start is ignored; start during a scan is ignored
    s0 = start_cnt;
    pulse_start(8'h00);
    repeat (30) @(negedge clk);
    check("mask0_starts", 32'(start_cnt), 32'(s0));
    check("mask0_busy", 32'(scan_busy), 32'd0);
    run_scan(8'h01, 16'h4000, 1'b1, "poke");

    // Reset while waiting on a transfer
    pulse_start(8'hFF);
    t = 0;
    while (!spi_busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("rstw_timeout", 32'(t < 200), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstw_spi_start", 32'(spi_start), 32'd0);
    check("rstw_cmd", 32'(spi_data_in), 32'd0);
    check("rstw_valid", 32'(sample_valid), 32'd0);
    check("rstw_data", 32'({sample_ch, sample_data}), 32'd0);
    check("rstw_busy", 32'(scan_busy), 32'd0);
    check("rstw_done", 32'(scan_done), 32'd0);
    check("rstw_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_scan(8'h96, 16'h5000, 1'b0, "after_rst");

    for (int r = 0; r < 6; r++)
      run_scan(NCH'($urandom_range(1, 255)), DW'($urandom), 1'b0, "rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
